irq_request_latch: RTL

- Upstream stage of the 8-to-3 priority encoder. It synchronises eight asynchronous request lines, detects their rising edges and holds each edge as a pending bit.
- Outputs the masked pending vector, which feeds the encoder's 8-bit input directly.
- Runs a valid/ack handshake with the consumer of the encoded index. An ack carrying the serviced index clears that pending bit.

---
 rtl/irq_pkg.sv | 35 +++
 rtl/irq_edge_sync.sv | 55 +++++
 rtl/irq_request_latch.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
//
// Shared definitions for the interrupt request latch that feeds the 8-to-3
// priority encoder.
//
// Contents:
//   N_IRQ        number of request lines (fixed at 8 by the encoder)
//   IRQ_IDXW     width of a line index, clog2(N_IRQ)
//   irq_state_t  handshake state: IDLE, PEND (request presented), GAP
//   onehot_idx   index -> one-hot line vector; out-of-range indices give 0
// -----------------------------------------------------------------------------
package irq_pkg;

   localparam int N_IRQ    = 8;
   localparam int IRQ_IDXW = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      GAP  = 2'd2
   } irq_state_t;

   // Decode a line index into a one-hot vector. Only indices below N_IRQ can
   // match, so any index at or beyond the line count decodes to all zeros.
   function automatic logic [N_IRQ-1:0] onehot_idx(input logic [IRQ_IDXW-1:0] idx);
      logic [N_IRQ-1:0] oh;
      oh = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         oh[i] = (int'(idx) == i);
      end
      return oh;
   endfunction

endpackage : irq_pkg

// File: rtl/irq_edge_sync.sv
// -----------------------------------------------------------------------------
// irq_edge_sync
//
// One request line: a SYNC_STAGES-deep synchroniser followed by a history
// flop. The history flop holds the previous synchronised value, so rise is
// high for exactly one cycle per low-to-high transition of the line.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth, 2 or 3
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset
//   irq_raw  in   asynchronous request line
//   rise     out  one-cycle pulse on a synchronised rising edge
//
// The history flop resets to 0, so a line held high through reset produces
// one edge once reset releases.
// -----------------------------------------------------------------------------
module irq_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic irq_raw,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_d;
   logic                   prev_q;

   // NOTE: every signal written here is assigned unconditionally, so no
   // latch can be inferred; next-state logic stays purely combinational.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], irq_raw};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   // NOTE: reset is sampled on the clock edge (synchronous), and all state
   // uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule : irq_edge_sync

// File: rtl/irq_request_latch.sv
// -----------------------------------------------------------------------------
// irq_request_latch
//
// Upstream stage of the 8-to-3 priority encoder. Each asynchronous request
// line is synchronised and edge-detected; every rising edge is held as a
// pending bit until the consumer acknowledges that line's index.
//
// Parameters:
//   N            request lines (the encoder fixes this at 8)
//   IDXW         ack index width, clog2(N)
//   SYNC_STAGES  synchroniser depth per line, 2 or 3
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   irq_raw    in   [N]     asynchronous request lines
//   irq_mask   in   [N]     1 = line enabled (synchronous to clk)
//   req_vec    out  [N]     pending & irq_mask, straight into the encoder
//   irq_valid  out          a masked request is being presented (state PEND)
//   ack_valid  in           one-cycle ack pulse from the consumer
//   ack_idx    in   [IDXW]  index of the line being serviced
//   pending    out  [N]     raw pending bits, unmasked, for status
//   lost       out  [N]     (IRQ_LOST_EN only) sticky: an edge arrived on a
//                           line that was already pending
//
// Build option:
//   IRQ_LOST_EN  when defined, adds the lost output and its flops. When not
//                defined the port does not exist; all else is identical.
//
// Handshake:
//   IDLE -> PEND  when any masked request exists
//   PEND -> GAP   on ack_valid (the indexed pending bit is cleared)
//   PEND -> IDLE  when masking removes every request before an ack
//   GAP  -> PEND  if requests remain, else IDLE (always exactly one cycle)
// Acks in IDLE or GAP are ignored entirely.
// -----------------------------------------------------------------------------
module irq_request_latch
   import irq_pkg::*;
#(
   parameter int N           = N_IRQ,
   parameter int IDXW        = IRQ_IDXW,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    irq_raw,
   input  logic [N-1:0]    irq_mask,
   output logic [N-1:0]    req_vec,
   output logic            irq_valid,
   input  logic            ack_valid,
   input  logic [IDXW-1:0] ack_idx,
   output logic [N-1:0]    pending
`ifdef IRQ_LOST_EN
   ,
   output logic [N-1:0]    lost
`endif
);

   // --------------------------------------------------------------------------
   // Per-line synchroniser and edge detector
   // --------------------------------------------------------------------------
   logic [N-1:0] rise;

   for (genvar g = 0; g < N; g++) begin : g_line
      irq_edge_sync #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_edge_sync (
         .clk     (clk),
         .rst_n   (rst_n),
         .irq_raw (irq_raw[g]),
         .rise    (rise[g])
      );
   end

   // --------------------------------------------------------------------------
   // Pending vector
   // --------------------------------------------------------------------------
   logic [N-1:0] pending_d;
   logic [N-1:0] pending_q;
   logic [N-1:0] clr;
   logic         ack_accept;
   logic         any_req;
   irq_state_t   state_d;
   irq_state_t   state_q;

   // The encoder sees every line driven: unpending or masked lines give 0.
   assign req_vec    = pending_q & irq_mask;
   assign any_req    = |req_vec;
   assign ack_accept = ack_valid && (state_q == PEND);

   always_comb begin
      clr       = ack_accept ? onehot_idx(ack_idx) : '0;
      // Rise is OR-ed in after the clear, so a new edge on the line being
      // acknowledged keeps its pending bit set.
      pending_d = (pending_q & ~clr) | rise;
   end

   // --------------------------------------------------------------------------
   // Handshake FSM
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (any_req) state_d = PEND;
         end
         PEND: begin
            // An ack always opens the gap, even if its index was not pending.
            if (ack_valid)     state_d = GAP;
            else if (!any_req) state_d = IDLE;
         end
         GAP: begin
            // One cycle for the encoder output to re-settle after the clear.
            state_d = any_req ? PEND : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
      end
   end

   assign pending   = pending_q;
   assign irq_valid = (state_q == PEND);

   // --------------------------------------------------------------------------
   // Lost-edge status
   // --------------------------------------------------------------------------
`ifdef IRQ_LOST_EN
   logic [N-1:0] lost_d;
   logic [N-1:0] lost_q;

   // A second edge is lost only if the bit it lands on stays pending; an edge
   // coinciding with that line's clear simply re-pends it. A clear drops the
   // lost bit unless a fresh loss is recorded in the same cycle.
   always_comb begin
      lost_d = (lost_q & ~clr) | (rise & pending_q & ~clr);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lost_q <= '0;
      end else begin
         lost_q <= lost_d;
      end
   end

   assign lost = lost_q;
`endif

endmodule : irq_request_latch
